// File: rtl/fu_jump_pipe_if.sv
// fu_jump_pipe_if: issue, writeback and result bundle for the pipelined jump unit
interface fu_jump_pipe_if #(
  parameter int XLEN = 32,
  parameter int TAG_W = 4
);
  logic EN;
  logic ready;
  logic JALR;
  logic [2:0] cmp_ctrl;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] PC;
  logic pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [TAG_W-1:0] tag_in;
  logic flush;
  logic wb_ack;
  logic finish;
  logic [TAG_W-1:0] tag_out;
  logic cmp_res;
  logic [XLEN-1:0] PC_jump;
  logic [XLEN-1:0] PC_wb;
  logic mispredict;
  modport master (
    output EN, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC, pred_taken, pred_target, tag_in, flush, wb_ack,
    input ready, finish, tag_out, cmp_res, PC_jump, PC_wb, mispredict
  );
  modport slave (
    input EN, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC, pred_taken, pred_target, tag_in, flush, wb_ack,
    output ready, finish, tag_out, cmp_res, PC_jump, PC_wb, mispredict
  );
endinterface

// File: rtl/fu_jump_pipe.sv
// fu_jump_pipe: pipelined branch/JAL/JALR unit with back-pressure, flush and mispredict detection
module fu_jump_pipe #(
  parameter int XLEN = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  fu_jump_pipe_if.slave bus
);
  typedef struct packed {
    logic v;
    logic jalr;
    logic [2:0] cc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic pt;
    logic [XLEN-1:0] ptgt;
    logic [TAG_W-1:0] tag;
  } op_t;
  op_t st [LATENCY];
  op_t nxt [LATENCY];
  op_t f;
  logic [LATENCY-1:0] adv;
  logic room;
  logic [XLEN-1:0] tgt, link, jump;
  logic eq, lt, ltu, taken;
  // a stage may take new contents when it or any stage below it is empty, or the head is acknowledged
  always_comb begin
    room = bus.wb_ack;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      room = room | ~st[k].v;
      adv[k] = room;
    end
  end
  assign bus.ready = adv[0];
  always_comb begin
    nxt[0] = '{v: bus.EN, jalr: bus.JALR, cc: bus.cmp_ctrl, rs1: bus.rs1_data, rs2: bus.rs2_data,
               imm: bus.imm, pc: bus.PC, pt: bus.pred_taken, ptgt: bus.pred_target, tag: bus.tag_in};
    for (int k = 1; k < LATENCY; k++) nxt[k] = st[k-1];
  end
  always_ff @(posedge clk) begin
    if (rst) for (int k = 0; k < LATENCY; k++) st[k] <= '0;
    else if (bus.flush) for (int k = 0; k < LATENCY; k++) st[k].v <= 1'b0;
    else for (int k = 0; k < LATENCY; k++) if (adv[k]) st[k] <= nxt[k];
  end
  assign f = st[LATENCY-1];
  always_comb begin
    tgt = (f.jalr ? f.rs1 : f.pc) + f.imm;
    tgt[0] = tgt[0] & ~f.jalr;
    link = f.pc + XLEN'(4);
    eq = f.rs1 == f.rs2;
    lt = $signed(f.rs1) < $signed(f.rs2);
    ltu = f.rs1 < f.rs2;
    taken = 1'b0;
    case (f.cc)
      3'b001: taken = eq;
      3'b010: taken = ~eq;
      3'b011: taken = lt;
      3'b100: taken = ~lt;
      3'b101: taken = ltu;
      3'b110: taken = ~ltu;
      3'b111: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    jump = taken ? tgt : link;
  end
  assign bus.finish = f.v;
  assign bus.tag_out = f.v ? f.tag : '0;
  assign bus.cmp_res = f.v & taken;
  assign bus.PC_jump = f.v ? jump : '0;
  assign bus.PC_wb = f.v ? link : '0;
  assign bus.mispredict = f.v & ((taken != f.pt) | (jump != f.ptgt));
endmodule

// File: tb/tb_fu_jump_pipe.sv
// tb_fu_jump_pipe: three configurations driven by shared stimulus, each checked against a result-queue model
module tb_fu_jump_pipe;
  typedef struct {
    logic [3:0] tag;
    logic cmp;
    logic [63:0] pcj;
    logic [63:0] pcw;
    logic mis;
    longint acc;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_tests = 0;
  int n_fail = 0;
  logic rst, en, jalr, pt, flush, wb_ack;
  logic [2:0] cc;
  logic [63:0] rs1, rs2, imm, pc, ptg;
  logic [3:0] tag;
  logic fin [3];
  logic rdy [3];
  logic cr [3];
  logic mis [3];
  logic [3:0] tgo [3];
  logic [63:0] pcj [3];
  logic [63:0] pcw [3];

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // architectural result of one op at width w, straight from the ISA rules
  function automatic exp_t ref_op(int w, logic j, logic [2:0] c, logic [63:0] a, logic [63:0] b,
                                  logic [63:0] im, logic [63:0] p, logic t, logic [63:0] tg, logic [3:0] tq);
    exp_t e;
    logic [63:0] m, sb, target, nxt;
    logic tk, slt;
    m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    sb = 64'd1 << (w - 1);
    a &= m; b &= m; im &= m; p &= m; tg &= m;
    target = ((j ? a : p) + im) & m;
    if (j) target[0] = 1'b0;
    slt = (a ^ sb) < (b ^ sb);
    case (c)
      3'd0: tk = 1'b0;
      3'd1: tk = a == b;
      3'd2: tk = a != b;
      3'd3: tk = slt;
      3'd4: tk = !slt;
      3'd5: tk = a < b;
      3'd6: tk = a >= b;
      default: tk = 1'b1;
    endcase
    e.pcw = (p + 64'd4) & m;
    nxt = tk ? target : e.pcw;
    e.tag = tq;
    e.cmp = tk;
    e.pcj = nxt;
    e.mis = (tk != t) || (nxt != tg);
    e.acc = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : h
    localparam int W = (g == 0) ? 32 : 64;
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    fu_jump_pipe_if #(.XLEN(W), .TAG_W(4)) bus ();
    fu_jump_pipe #(.XLEN(W), .LATENCY(L), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.EN = en;
    assign bus.JALR = jalr;
    assign bus.cmp_ctrl = cc;
    assign bus.rs1_data = rs1[W-1:0];
    assign bus.rs2_data = rs2[W-1:0];
    assign bus.imm = imm[W-1:0];
    assign bus.PC = pc[W-1:0];
    assign bus.pred_taken = pt;
    assign bus.pred_target = ptg[W-1:0];
    assign bus.tag_in = tag;
    assign bus.flush = flush;
    assign bus.wb_ack = wb_ack;
    assign fin[g] = bus.finish;
    assign rdy[g] = bus.ready;
    assign cr[g] = bus.cmp_res;
    assign mis[g] = bus.mispredict;
    assign tgo[g] = bus.tag_out;
    assign pcj[g] = 64'(bus.PC_jump);
    assign pcw[g] = 64'(bus.PC_wb);
    exp_t q[$];
    longint dep = 0;
    // the head is presented once it has aged L-1 edges and its predecessor has been acknowledged
    always @(negedge clk) begin : chk
      exp_t e;
      logic ef, er;
      longint due;
      if (cyc > 0) begin
        due = (q.size() > 0) ? q[0].acc + L - 1 : 0;
        if (dep > due) due = dep;
        ef = q.size() > 0 && cyc >= due;
        er = (q.size() < L) || wb_ack;
        check($sformatf("finish[%0d]", g), 64'(fin[g]), 64'(ef));
        check($sformatf("ready[%0d]", g), 64'(rdy[g]), 64'(er));
        if (ef) begin
          check($sformatf("tag_out[%0d]", g), 64'(tgo[g]), 64'(q[0].tag));
          check($sformatf("cmp_res[%0d]", g), 64'(cr[g]), 64'(q[0].cmp));
          check($sformatf("PC_jump[%0d]", g), pcj[g], q[0].pcj);
          check($sformatf("PC_wb[%0d]", g), pcw[g], q[0].pcw);
          check($sformatf("mispredict[%0d]", g), 64'(mis[g]), 64'(q[0].mis));
        end else begin
          check($sformatf("idle_zero[%0d]", g), pcj[g] | pcw[g] | 64'({cr[g], mis[g]}), 64'd0);
        end
        if (rst || flush) q.delete();
        else begin
          if (ef && wb_ack) begin
            void'(q.pop_front());
            dep = cyc + 1;
          end
          if (en && er) begin
            e = ref_op(W, jalr, cc, rs1, rs2, imm, pc, pt, ptg, tag);
            e.acc = cyc + 1;
            q.push_back(e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(logic j, logic [2:0] c, logic [63:0] a, logic [63:0] b, logic [63:0] im,
                       logic [63:0] p, logic t, logic [63:0] tg, logic [3:0] tq);
    jalr = j; cc = c; rs1 = a; rs2 = b; imm = im; pc = p; pt = t; ptg = tg; tag = tq;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 4))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 8));
      2: return '1;
      3: return 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 3));
      default: return 64'h0000_0000_FFFF_FFFF ^ 64'($urandom_range(0, 1));
    endcase
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; wb_ack = 1'b1;
    setop(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    setop(0, 3'b001, 5, 5, 64'h20, 64'h100, 1, 64'h120, 3);
    en = 1'b1;
    @(negedge clk);
    check("rst_finish", 64'(fin[0]), 0);
    check("rst_ready", 64'(rdy[0]), 1);
    check("rst_outs", pcj[0] | pcw[0] | 64'({cr[0], mis[0], tgo[0]}), 0);
    step();
    en = 1'b0;
    @(negedge clk);
    check("beq_lat2_early", 64'(fin[0]), 0);
    check("beq_lat1_finish", 64'(fin[1]), 1);
    check("beq_lat1_wb", pcw[1], 64'h104);
    step();
    @(negedge clk);
    check("beq_finish", 64'(fin[0]), 1);
    check("beq_cmp", 64'(cr[0]), 1);
    check("beq_jump", pcj[0], 64'h120);
    check("beq_wb", pcw[0], 64'h104);
    check("beq_mis", 64'(mis[0]), 0);
    check("beq_tag", 64'(tgo[0]), 3);
    check("beq_lat4_early", 64'(fin[2]), 0);
    step(); step();
    @(negedge clk);
    check("beq_lat4_finish", 64'(fin[2]), 1);
    step();
    setop(1, 3'b111, 64'h1001, 0, 64'h4, 64'h200, 1, 64'h204, 5);
    en = 1'b1;
    step();
    en = 1'b0;
    step();
    @(negedge clk);
    check("jalr_jump", pcj[0], 64'h1004);
    check("jalr_wb", pcw[0], 64'h204);
    check("jalr_cmp", 64'(cr[0]), 1);
    check("jalr_mis", 64'(mis[0]), 1);
    step();
    setop(0, 3'b011, 64'hFFFF_FFFF, 1, 8, 64'h300, 0, 64'h304, 6);
    en = 1'b1;
    step();
    cc = 3'b101; tag = 7;
    step();
    en = 1'b0;
    @(negedge clk);
    check("slt_cmp", 64'(cr[0]), 1);
    check("slt_tag", 64'(tgo[0]), 6);
    step();
    @(negedge clk);
    check("sltu_cmp", 64'(cr[0]), 0);
    check("sltu_tag", 64'(tgo[0]), 7);
    step();
    setop(0, 3'b111, 0, 0, 8, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h4, 8);
    en = 1'b1;
    step();
    en = 1'b0;
    @(negedge clk);
    check("wrap64_wb", pcw[1], 0);
    check("wrap64_jump", pcj[1], 64'h4);
    step();
    @(negedge clk);
    check("wrap32_wb", pcw[0], 0);
    step();
    wb_ack = 1'b0;
    setop(0, 3'b010, 1, 2, 64'h40, 64'h400, 1, 64'h440, 1);
    en = 1'b1;
    step();
    tag = 2;
    step();
    tag = 3;
    @(negedge clk);
    check("bp_ready_low", 64'(rdy[0]), 0);
    check("bp_finish", 64'(fin[0]), 1);
    check("bp_tag_hold", 64'(tgo[0]), 1);
    step();
    @(negedge clk);
    check("bp_tag_hold2", 64'(tgo[0]), 1);
    check("bp_jump_hold", pcj[0], 64'h440);
    step();
    wb_ack = 1'b1;
    @(negedge clk);
    check("bp_ready_adv", 64'(rdy[0]), 1);
    check("bp_drain1", 64'(tgo[0]), 1);
    step();
    tag = 4;
    @(negedge clk);
    check("bp_drain2", 64'(tgo[0]), 2);
    step();
    en = 1'b0;
    @(negedge clk);
    check("bp_drain3", 64'(tgo[0]), 3);
    step();
    @(negedge clk);
    check("bp_drain4", 64'(tgo[0]), 4);
    step();
    @(negedge clk);
    check("bp_empty", 64'(fin[0]), 0);
    step();
    wb_ack = 1'b0;
    setop(0, 3'b111, 0, 0, 64'h10, 64'h500, 1, 64'h510, 8);
    en = 1'b1;
    step();
    tag = 9;
    step();
    tag = 10;
    flush = 1'b1;
    step();
    flush = 1'b0;
    en = 1'b0;
    wb_ack = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("flush_finish[%0d]", g), 64'(fin[g]), 0);
      check($sformatf("flush_ready[%0d]", g), 64'(rdy[g]), 1);
    end
    repeat (6) step();
    repeat (2000) begin
      step();
      rst = $urandom_range(0, 199) == 0;
      flush = $urandom_range(0, 39) == 0;
      en = $urandom_range(0, 9) < 7;
      wb_ack = $urandom_range(0, 9) < 7;
      jalr = 1'($urandom_range(0, 1));
      cc = 3'($urandom_range(0, 7));
      rs1 = pick();
      rs2 = $urandom_range(0, 3) == 0 ? rs1 : pick();
      imm = $urandom_range(0, 1) ? 64'($urandom_range(0, 64)) : pick();
      pc = {$urandom, $urandom} & ~64'h3;
      pt = 1'($urandom_range(0, 1));
      tag = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: ptg = pc + 64'd4;
        1: ptg = (jalr ? rs1 : pc) + imm;
        default: ptg = {$urandom, $urandom};
      endcase
    end
    step();
    rst = 1'b0; flush = 1'b0; en = 1'b0; wb_ack = 1'b1;
    repeat (8) step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fu_jump_pipe.md
# fu_jump_pipe

Parametrised, pipelined branch/jump functional unit for the dynamically scheduled core. It accepts one branch, JAL or JALR operation per cycle from the issue stage. It resolves the branch condition and the target, computes the link value, and compares the outcome against the front-end prediction. Each result is held on the common data bus side until it is acknowledged. It replaces the fixed two-cycle, non-pipelined jump unit and adds configurable latency, tag passthrough, back-pressure, flush and mispredict detection.

## Interface
- XLEN, 32, datapath width (≥ 8).
- LATENCY, 2, cycles from issue to result valid (≥ 1).
- TAG_W, 4, width of the reservation-station/ROB tag carried with each operation.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- EN  in  1  issue valid.
- ready  out  1  unit can accept an issue this cycle.
- JALR  in  1  target base is rs1_data (else PC).
- cmp_ctrl  in  3  condition: 000 never, 001 EQ, 010 NE, 011 LT, 100 GE, 101 LTU, 110 GEU, 111 always (JAL/JALR).
- rs1_data, rs2_data, imm, PC  in  XLEN  operands.
- pred_taken  in  1  front-end predicted direction.
- pred_target  in  XLEN  front-end predicted next PC.
- tag_in  in  TAG_W  operation tag.
- flush  in  1  kill all in-flight operations.
- wb_ack  in  1  writeback consumed the current result.
- finish  out  1  result valid.
- tag_out  out  TAG_W  tag of the current result.
- cmp_res  out  1  resolved taken.
- PC_jump  out  XLEN  resolved next PC: target if taken, else PC+4.
- PC_wb  out  XLEN  link value, PC+4.
- mispredict  out  1  resolved next PC differs from the prediction.

## Operation
- Issue is accepted when EN & ready & ~flush. Operands are captured into stage 1 of a LATENCY-deep pipeline, and each stage has a valid bit.
- Arithmetic is modulo 2^XLEN.
  - target = (JALR ? rs1_data : PC) + imm.
  - For JALR, target bit 0 is forced to 0.
  - PC_wb = PC + 4.
- Signed compares (LT/GE) are two's complement. Unsigned compares (LTU/GEU) are unsigned.
- cmp_res = condition result. Code 111 always gives 1 and code 000 always gives 0.
- PC_jump = cmp_res ? target : PC+4.
- mispredict = (cmp_res ≠ pred_taken) | (PC_jump ≠ pred_target). Both terms are evaluated on the registered operands.
- Computation may be placed in any stage. The outputs must be a pure function of the final stage's registers.
- Stage advance rule:
  - The final stage holds while finish & ~wb_ack.
  - Stage k advances when stage k+1 is empty or advancing.
  - ready = stage 1 empty or advancing.
- No internal states beyond the per-stage valid bits. Each stage is either empty or holding an op; ops are never reordered or dropped except by flush/rst.

## Timing
- Reset and flush behaviour:
  - rst (synchronous) clears all valid bits. After the reset edge: finish=0, ready=1, mispredict=0, cmp_res=0, tag_out=0, PC_jump=0, PC_wb=0.
  - flush clears all valid bits at the next edge, and an issue in the same cycle is dropped. In the following cycle finish=0 and ready=1.
  - rst overrides flush, and flush overrides wb_ack/EN.
- Latency: an op accepted at edge t gives finish=1 in the cycle after edge t+LATENCY−1, i.e. LATENCY cycles after the issue cycle, when there is no back-pressure.
- Throughput: one op per cycle while wb_ack is held high.
- finish=1 with wb_ack=0 holds every output stable. Upstream stages fill. Once all stages are full, ready=0.
- wb_ack with finish=0 is ignored.
- finish & wb_ack, with a valid op in the preceding stage, presents the next result in the next cycle with no bubble.
- Issue while full and wb_ack=1 in the same cycle is accepted (ready=1 combinationally via advance).
- mispredict, cmp_res, PC_jump and PC_wb are meaningful only while finish=1. They are driven 0 when finish=0.

## Test plan
- Reset and BEQ, LATENCY=2:
  - Stimulus: rst for 2 cycles, then EN with cmp_ctrl=001, rs1=rs2=5, PC=0x100, imm=0x20, pred_taken=1, pred_target=0x120, tag=3, wb_ack=1.
  - Response: finish high exactly 2 cycles after issue; cmp_res=1, PC_jump=0x120, PC_wb=0x104, mispredict=0, tag_out=3.
- JALR alignment and mispredict:
  - Stimulus: JALR=1, cmp_ctrl=111, rs1=0x1001, imm=0x4, PC=0x200, pred_target=0x204.
  - Response: PC_jump=0x1004, PC_wb=0x204, cmp_res=1, mispredict=1.
- Signed vs unsigned:
  - Stimulus: rs1=0xFFFFFFFF, rs2=1; cmp_ctrl=011 then 101 back-to-back.
  - Response: cmp_res=1 then 0, on consecutive finish cycles.
- Back-pressure:
  - Stimulus: issue 4 ops (tags 1–4) on consecutive cycles with wb_ack=0.
  - Response: ready drops after LATENCY accepts; outputs stay frozen on tag 1; releasing wb_ack delivers tags 1..4 in order, one per cycle; no op is lost.
- Flush mid-flight:
  - Stimulus: 2 ops in flight, flush with a simultaneous EN.
  - Response: finish=0 the next cycle, ready=1, no result ever appears for the flushed or dropped ops.
- Parameter sweep:
  - Stimulus: repeat the first test with LATENCY=1 and LATENCY=4, XLEN=64.
  - Response: finish delay equals LATENCY; the PC+4 wrap from 0xFFFF_FFFF_FFFF_FFFC gives PC_wb=0.
